// File: rtl/w0rm_core_writeback_if.sv
// Result/commit bundle between the execution units, the writeback stage and the register file.
// The slave modport is the writeback stage; the master modport is whatever drives it.
interface w0rm_core_writeback_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 16,
   parameter int FIFO_DEPTH    = 2
);
   localparam int REG_ADDR_BITS = $clog2(NUM_REGISTERS);
   localparam int CNT_BITS      = $clog2(FIFO_DEPTH) + 1;

   logic                     alu_result_valid;
   logic                     alu_result_write;
   logic [REG_ADDR_BITS-1:0] alu_result_addr;
   logic [DATA_WIDTH-1:0]    alu_result_data;
   logic                     alu_result_ready;

   logic                     mem_result_valid;
   logic [REG_ADDR_BITS-1:0] mem_result_addr;
   logic [DATA_WIDTH-1:0]    mem_result_data;
   logic                     mem_result_ready;

   logic [REG_ADDR_BITS-1:0] port_write_addr;
   logic                     port_write_enable;
   logic [DATA_WIDTH-1:0]    port_write_data;

   logic [NUM_REGISTERS-1:0] pending_mask;
   logic [CNT_BITS-1:0]      fifo_count;

   modport slave (
      input  alu_result_valid, alu_result_write, alu_result_addr, alu_result_data,
      output alu_result_ready,
      input  mem_result_valid, mem_result_addr, mem_result_data,
      output mem_result_ready,
      output port_write_addr, port_write_enable, port_write_data,
      output pending_mask, fifo_count
   );

   modport master (
      output alu_result_valid, alu_result_write, alu_result_addr, alu_result_data,
      input  alu_result_ready,
      output mem_result_valid, mem_result_addr, mem_result_data,
      input  mem_result_ready,
      input  port_write_addr, port_write_enable, port_write_data,
      input  pending_mask, fifo_count
   );
endinterface

// File: rtl/w0rm_core_writeback.sv
// W0RM writeback: merges memory results (priority, starvation-bounded) and FIFO-buffered
// ALU results onto the single register-file write port, exporting a pending-write mask.
module w0rm_core_writeback #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 16,
   parameter int FIFO_DEPTH    = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   w0rm_core_writeback_if.slave wb
);
   localparam int REG_ADDR_BITS = $clog2(NUM_REGISTERS);
   localparam int PTR_BITS      = $clog2(FIFO_DEPTH);
   localparam int CNT_BITS      = PTR_BITS + 1;
   localparam int SC_BITS       = $clog2(STARVE_LIMIT + 1);

   logic [REG_ADDR_BITS-1:0] fifo_addr_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    fifo_data_mem [FIFO_DEPTH];

   logic [PTR_BITS-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0]      count_q, count_d;
   logic [SC_BITS-1:0]       starve_cnt_q, starve_cnt_d;
   logic                     port_we_q, port_we_d;
   logic [REG_ADDR_BITS-1:0] port_addr_q, port_addr_d;
   logic [DATA_WIDTH-1:0]    port_data_q, port_data_d;

   logic fifo_nonempty, fifo_full, starved, mem_ready;
   logic grant_fifo, grant_mem, push;
   logic [NUM_REGISTERS-1:0] entry_mask [FIFO_DEPTH];
   logic [NUM_REGISTERS-1:0] pending;

   always_comb begin
      fifo_nonempty = (count_q != '0);
      fifo_full     = (count_q == CNT_BITS'(FIFO_DEPTH));
      starved       = fifo_nonempty && (starve_cnt_q == SC_BITS'(STARVE_LIMIT));
      mem_ready     = !starved;
      grant_fifo    = fifo_nonempty && (starved || !wb.mem_result_valid);
      grant_mem     = wb.mem_result_valid && mem_ready;
      push          = wb.alu_result_valid && !fifo_full && wb.alu_result_write;
   end

   always_comb begin
      wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d     = grant_fifo ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d      = count_q;
      if (push && !grant_fifo)
         count_d = count_q + 1'b1;
      else if (!push && grant_fifo)
         count_d = count_q - 1'b1;

      // The counter only tracks memory wins while ALU results are actually waiting.
      starve_cnt_d = starve_cnt_q;
      if (grant_fifo || !fifo_nonempty)
         starve_cnt_d = '0;
      else if (grant_mem && starve_cnt_q != SC_BITS'(STARVE_LIMIT))
         starve_cnt_d = starve_cnt_q + 1'b1;

      port_we_d   = grant_fifo || grant_mem;
      port_addr_d = port_addr_q;
      port_data_d = port_data_q;
      if (grant_mem) begin
         port_addr_d = wb.mem_result_addr;
         port_data_d = wb.mem_result_data;
      end else if (grant_fifo) begin
         port_addr_d = fifo_addr_mem[rd_ptr_q];
         port_data_d = fifo_data_mem[rd_ptr_q];
      end
   end

   // Buffered entries are invalidated by count alone, so the storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_mem[wr_ptr_q] <= wb.alu_result_addr;
         fifo_data_mem[wr_ptr_q] <= wb.alu_result_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         starve_cnt_q <= '0;
         port_we_q    <= 1'b0;
         port_addr_q  <= '0;
         port_data_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         starve_cnt_q <= starve_cnt_d;
         port_we_q    <= port_we_d;
         port_addr_q  <= port_addr_d;
         port_data_q  <= port_data_d;
      end
   end

   // An entry is live when its distance from the read pointer is below the occupancy.
   for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [PTR_BITS-1:0] offset;
      assign offset = PTR_BITS'(gi) - rd_ptr_q;
      assign entry_mask[gi] = ({1'b0, offset} < count_q)
                            ? (NUM_REGISTERS'(1) << fifo_addr_mem[gi]) : '0;
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         pending = pending | entry_mask[i];
   end

   assign wb.alu_result_ready  = !fifo_full;
   assign wb.mem_result_ready  = mem_ready;
   assign wb.port_write_enable = port_we_q;
   assign wb.port_write_addr   = port_addr_q;
   assign wb.port_write_data   = port_data_q;
   assign wb.pending_mask      = pending;
   assign wb.fifo_count        = count_q;
endmodule

// File: tb/tb_w0rm_core_writeback.sv
// Directed bench for w0rm_core_writeback: one task per scenario, inline checks,
// inputs driven just after the rising edge, outputs sampled on the falling edge.
module tb_w0rm_core_writeback;
   logic clk;
   logic reset_n;
   int   total;
   int   bad;

   w0rm_core_writeback_if #(.DATA_WIDTH(32), .NUM_REGISTERS(16), .FIFO_DEPTH(2)) wb ();

   w0rm_core_writeback #(
      .DATA_WIDTH(32), .NUM_REGISTERS(16), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .wb(wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [36:0] port_obs;
   assign port_obs = {wb.port_write_enable, wb.port_write_addr, wb.port_write_data};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      wb.alu_result_valid = 1'b0;
      wb.alu_result_write = 1'b0;
      wb.alu_result_addr  = '0;
      wb.alu_result_data  = '0;
      wb.mem_result_valid = 1'b0;
      wb.mem_result_addr  = '0;
      wb.mem_result_data  = '0;
   endtask

   task automatic drive_alu(input logic [3:0] a, input logic [31:0] d);
      wb.alu_result_valid = 1'b1;
      wb.alu_result_write = 1'b1;
      wb.alu_result_addr  = a;
      wb.alu_result_data  = d;
   endtask

   task automatic drive_mem(input logic [3:0] a, input logic [31:0] d);
      wb.mem_result_valid = 1'b1;
      wb.mem_result_addr  = a;
      wb.mem_result_data  = d;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      idle_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (port_obs !== 37'd0) begin
         bad++; $display("FAIL reset_port got=%h want=%h", port_obs, 37'd0);
      end
      total++;
      if ({wb.pending_mask, wb.fifo_count} !== 18'd0) begin
         bad++; $display("FAIL reset_mask_count got=%h want=0", {wb.pending_mask, wb.fifo_count});
      end
      total++;
      if ({wb.alu_result_ready, wb.mem_result_ready} !== 2'b11) begin
         bad++; $display("FAIL reset_ready got=%b want=11", {wb.alu_result_ready, wb.mem_result_ready});
      end
      reset_n = 1'b1;
      tick();
      @(negedge clk);
      total++;
      if ({port_obs, wb.fifo_count} !== 39'd0) begin
         bad++; $display("FAIL post_reset_idle got=%h want=0", {port_obs, wb.fifo_count});
      end
      tick();
   endtask

   task automatic test_alu_path;
      drive_alu(4'd3, 32'hDEADBEEF);
      tick();
      idle_inputs();
      @(negedge clk);
      total++;
      if ({wb.pending_mask, wb.fifo_count, wb.port_write_enable} !== {16'h0008, 2'd1, 1'b0}) begin
         bad++; $display("FAIL alu_pending got=%h/%0d/%b want=0008/1/0",
                         wb.pending_mask, wb.fifo_count, wb.port_write_enable);
      end
      tick();
      @(negedge clk);
      total++;
      if (port_obs !== {1'b1, 4'd3, 32'hDEADBEEF}) begin
         bad++; $display("FAIL alu_write got=%h want=%h", port_obs, {1'b1, 4'd3, 32'hDEADBEEF});
      end
      total++;
      if ({wb.pending_mask, wb.fifo_count} !== 18'd0) begin
         bad++; $display("FAIL alu_drain got=%h/%0d want=0/0", wb.pending_mask, wb.fifo_count);
      end
      tick();
      @(negedge clk);
      total++;
      if (port_obs !== {1'b0, 4'd3, 32'hDEADBEEF}) begin
         bad++; $display("FAIL alu_hold got=%h want=%h", port_obs, {1'b0, 4'd3, 32'hDEADBEEF});
      end
      tick();
   endtask

   task automatic test_mem_path;
      drive_mem(4'd5, 32'h12345678);
      tick();
      idle_inputs();
      @(negedge clk);
      total++;
      if (port_obs !== {1'b1, 4'd5, 32'h12345678}) begin
         bad++; $display("FAIL mem_write got=%h want=%h", port_obs, {1'b1, 4'd5, 32'h12345678});
      end
      tick();
      @(negedge clk);
      total++;
      if (port_obs !== {1'b0, 4'd5, 32'h12345678}) begin
         bad++; $display("FAIL mem_hold got=%h want=%h", port_obs, {1'b0, 4'd5, 32'h12345678});
      end
      tick();
   endtask

   task automatic test_no_write;
      wb.alu_result_valid = 1'b1;
      wb.alu_result_write = 1'b0;
      wb.alu_result_addr  = 4'd7;
      wb.alu_result_data  = 32'hCAFE0007;
      @(negedge clk);
      total++;
      if (wb.alu_result_ready !== 1'b1) begin
         bad++; $display("FAIL nowrite_ready got=%b want=1", wb.alu_result_ready);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      total++;
      if ({wb.fifo_count, wb.pending_mask} !== 18'd0) begin
         bad++; $display("FAIL nowrite_count got=%0d/%h want=0/0", wb.fifo_count, wb.pending_mask);
      end
      tick();
      @(negedge clk);
      total++;
      if (port_obs !== {1'b0, 4'd5, 32'h12345678}) begin
         bad++; $display("FAIL nowrite_strobe got=%h want=%h", port_obs, {1'b0, 4'd5, 32'h12345678});
      end
      tick();
   endtask

   task automatic test_back_to_back;
      drive_alu(4'd10, 32'hB0);
      tick();
      drive_alu(4'd11, 32'hB1);
      @(negedge clk);
      total++;
      if ({wb.fifo_count, wb.pending_mask} !== {2'd1, 16'h0400}) begin
         bad++; $display("FAIL b2b_c1 got=%0d/%h want=1/0400", wb.fifo_count, wb.pending_mask);
      end
      tick();
      drive_alu(4'd12, 32'hB2);
      @(negedge clk);
      total++;
      if ({port_obs, wb.fifo_count, wb.pending_mask} !== {1'b1, 4'd10, 32'hB0, 2'd1, 16'h0800}) begin
         bad++; $display("FAIL b2b_c2 got=%h/%0d/%h want=r10/1/0800", port_obs, wb.fifo_count, wb.pending_mask);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      total++;
      if ({port_obs, wb.fifo_count, wb.pending_mask} !== {1'b1, 4'd11, 32'hB1, 2'd1, 16'h1000}) begin
         bad++; $display("FAIL b2b_c3 got=%h/%0d/%h want=r11/1/1000", port_obs, wb.fifo_count, wb.pending_mask);
      end
      tick();
      @(negedge clk);
      total++;
      if ({port_obs, wb.fifo_count} !== {1'b1, 4'd12, 32'hB2, 2'd0}) begin
         bad++; $display("FAIL b2b_c4 got=%h/%0d want=r12/0", port_obs, wb.fifo_count);
      end
      tick();
   endtask

   task automatic test_starvation;
      logic [36:0] exp;
      drive_alu(4'd1, 32'hA1);
      tick();
      drive_alu(4'd2, 32'hA2);
      for (int k = 0; k < 4; k++) begin
         if (k == 1) wb.alu_result_valid = 1'b0;
         drive_mem(4'(8 + k), 32'h1000 + 32'(k));
         @(negedge clk);
         total++;
         if ({wb.mem_result_ready, wb.alu_result_ready} !== {1'b1, (k == 0)}) begin
            bad++; $display("FAIL starve_ready k=%0d got=%b%b want=1%b", k,
                            wb.mem_result_ready, wb.alu_result_ready, (k == 0));
         end
         if (k > 0) begin
            exp = {1'b1, 4'(8 + k - 1), 32'h1000 + 32'(k - 1)};
            total++;
            if (port_obs !== exp) begin
               bad++; $display("FAIL starve_mem k=%0d got=%h want=%h", k, port_obs, exp);
            end
         end
         tick();
      end
      drive_mem(4'd12, 32'h1004);
      @(negedge clk);
      total++;
      if ({wb.mem_result_ready, wb.pending_mask} !== {1'b0, 16'h0006}) begin
         bad++; $display("FAIL starve_grant got=%b/%h want=0/0006", wb.mem_result_ready, wb.pending_mask);
      end
      exp = {1'b1, 4'd11, 32'h1003};
      total++;
      if (port_obs !== exp) begin
         bad++; $display("FAIL starve_mem3 got=%h want=%h", port_obs, exp);
      end
      tick();
      for (int k = 4; k < 8; k++) begin
         drive_mem(4'(8 + k), 32'h1000 + 32'(k));
         @(negedge clk);
         exp = (k == 4) ? {1'b1, 4'd1, 32'hA1} : {1'b1, 4'(8 + k - 1), 32'h1000 + 32'(k - 1)};
         total++;
         if ({port_obs, wb.mem_result_ready} !== {exp, 1'b1}) begin
            bad++; $display("FAIL starve_round2 k=%0d got=%h/%b want=%h/1", k, port_obs, wb.mem_result_ready, exp);
         end
         tick();
      end
      drive_mem(4'd0, 32'h2000);
      @(negedge clk);
      total++;
      if ({wb.mem_result_ready, port_obs} !== {1'b0, 1'b1, 4'd15, 32'h1007}) begin
         bad++; $display("FAIL starve_grant2 got=%b/%h want=0/m7", wb.mem_result_ready, port_obs);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      total++;
      if ({port_obs, wb.fifo_count, wb.pending_mask} !== {1'b1, 4'd2, 32'hA2, 2'd0, 16'h0}) begin
         bad++; $display("FAIL starve_r2 got=%h/%0d/%h want=r2/0/0", port_obs, wb.fifo_count, wb.pending_mask);
      end
      tick();
   endtask

   task automatic test_async_reset;
      drive_alu(4'd4, 32'hC4);
      tick();
      drive_alu(4'd6, 32'hC6);
      drive_mem(4'd9, 32'h99);
      tick();
      wb.alu_result_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({wb.fifo_count, wb.pending_mask, wb.port_write_enable} !== {2'd2, 16'h0050, 1'b1}) begin
         bad++; $display("FAIL arst_pre got=%0d/%h/%b want=2/0050/1",
                         wb.fifo_count, wb.pending_mask, wb.port_write_enable);
      end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if ({port_obs, wb.pending_mask, wb.fifo_count} !== 55'd0) begin
         bad++; $display("FAIL arst_now got=%h/%h/%0d want=0/0/0", port_obs, wb.pending_mask, wb.fifo_count);
      end
      total++;
      if ({wb.alu_result_ready, wb.mem_result_ready} !== 2'b11) begin
         bad++; $display("FAIL arst_ready got=%b%b want=11", wb.alu_result_ready, wb.mem_result_ready);
      end
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if ({wb.port_write_enable, wb.fifo_count, wb.pending_mask} !== 19'd0) begin
            bad++; $display("FAIL arst_after i=%0d got=%b/%0d/%h want=0/0/0", i,
                            wb.port_write_enable, wb.fifo_count, wb.pending_mask);
         end
      end
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_alu_path();
      test_mem_path();
      test_no_write();
      test_back_to_back();
      test_starvation();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
